// File: rtl/fp_addsub_seq_pkg.sv
// Shared definitions for the sequential floating-point adder: FSM state encodings
// and the exception flag bundle carried from UNPACK to the result bus.
package fp_addsub_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5,
        ST_OUT    = 3'd6
    } state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic invalid;
    } flags_t;

    localparam flags_t FLAGS_NONE = '0;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor, one operation in flight.
// IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> OUT; result published 6 edges after accept.
module fp_addsub_seq
    import fp_addsub_seq_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int ROUND_MODE = 0,
    localparam int W         = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_overflow,
    output logic         out_underflow,
    output logic         out_invalid
);

    localparam int XW  = MAN_W + 4;      // hidden + mantissa + G,R,S
    localparam int SW  = MAN_W + 5;      // XW plus carry
    localparam int EW  = EXP_W + 2;      // exponent with headroom and sign
    localparam int LZW = $clog2(XW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W:0]   SHIFT_LIM = (EXP_W + 1)'(XW);

    function automatic logic [W-1:0] inf_word(input logic s);
        return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

    function automatic logic [W-1:0] zero_word(input logic s);
        return {s, {(W-1){1'b0}}};
    endfunction

    state_t state, state_next;

    logic [W-1:0]     a_q, b_q;
    logic             op_q;

    logic             spec_q;
    logic [W-1:0]     spec_word_q;
    flags_t           spec_flags_q;
    logic             ua_sign, ub_sign;
    logic [EXP_W-1:0] ua_exp, ub_exp;
    logic [MAN_W-1:0] ua_man, ub_man;

    logic             al_sign, al_sub;
    logic [EXP_W-1:0] al_exp;
    logic [XW-1:0]    al_big, al_small;

    logic [SW-1:0]    ad_sum;
    logic             ad_sign;
    logic [EXP_W-1:0] ad_exp;

    logic [XW-1:0]    nm_sig;
    logic [EW-1:0]    nm_exp;
    logic             nm_sign, nm_zero, nm_underflow;

    logic [W-1:0]     res_word;
    flags_t           res_flags;
    flags_t           out_flags;

    // UNPACK
    logic             u_sign_a, u_sign_b;
    logic [EXP_W-1:0] u_exp_a, u_exp_b;
    logic [MAN_W-1:0] u_man_a, u_man_b;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             u_spec;
    logic [W-1:0]     u_word;
    flags_t           u_flags;

    always_comb begin
        u_sign_a = a_q[W-1];
        u_exp_a  = a_q[W-2:MAN_W];
        u_man_a  = a_q[MAN_W-1:0];
        u_sign_b = b_q[W-1] ^ op_q;
        u_exp_b  = b_q[W-2:MAN_W];
        u_man_b  = b_q[MAN_W-1:0];
        a_nan    = (u_exp_a == EXP_ONES) && (u_man_a != '0);
        b_nan    = (u_exp_b == EXP_ONES) && (u_man_b != '0);
        a_inf    = (u_exp_a == EXP_ONES) && (u_man_a == '0);
        b_inf    = (u_exp_b == EXP_ONES) && (u_man_b == '0);
        a_zero   = (u_exp_a == '0);
        b_zero   = (u_exp_b == '0);
        u_spec   = 1'b1;
        u_word   = '0;
        u_flags  = FLAGS_NONE;
        if (a_nan || b_nan || (a_inf && b_inf && (u_sign_a != u_sign_b))) begin
            u_word          = '1;
            u_flags.invalid = 1'b1;
        end else if (a_inf) begin
            u_word = inf_word(u_sign_a);
        end else if (b_inf) begin
            u_word = inf_word(u_sign_b);
        end else if (a_zero && b_zero) begin
            u_word = zero_word(u_sign_a | u_sign_b);
        end else if (b_zero) begin
            u_word = a_q;
        end else if (a_zero) begin
            u_word = {u_sign_b, b_q[W-2:0]};
        end else begin
            u_spec = 1'b0;
        end
    end

    // ALIGN
    logic             a_bigger;
    logic             big_sign;
    logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
    logic [MAN_W-1:0] big_man, small_man;
    logic [XW-1:0]    small_ext, lost_mask, small_aligned;

    always_comb begin
        a_bigger  = {ua_exp, ua_man} >= {ub_exp, ub_man};
        big_sign  = a_bigger ? ua_sign : ub_sign;
        big_exp   = a_bigger ? ua_exp  : ub_exp;
        big_man   = a_bigger ? ua_man  : ub_man;
        small_exp = a_bigger ? ub_exp  : ua_exp;
        small_man = a_bigger ? ub_man  : ua_man;
        exp_diff  = big_exp - small_exp;
        small_ext = {1'b1, small_man, 3'b000};
        lost_mask = ~({XW{1'b1}} << exp_diff);
        if ({1'b0, exp_diff} >= SHIFT_LIM) begin
            small_aligned = {{(XW-1){1'b0}}, 1'b1};
        end else begin
            small_aligned = (small_ext >> exp_diff)
                          | {{(XW-1){1'b0}}, |(small_ext & lost_mask)};
        end
    end

    // ADD: operands are ordered, so the difference never goes negative.
    logic [SW-1:0] sum_next;

    always_comb begin
        if (al_sub) begin
            sum_next = {1'b0, al_big} - {1'b0, al_small};
        end else begin
            sum_next = {1'b0, al_big} + {1'b0, al_small};
        end
    end

    // NORM
    logic [LZW-1:0] lz_count;
    logic [XW-1:0]  n_sig;
    logic [EW-1:0]  n_exp;
    logic           n_zero, n_underflow;

    fp_lzc #(.WIDTH(XW)) u_lzc (
        .value (ad_sum[XW-1:0]),
        .count (lz_count)
    );

    always_comb begin
        n_zero = (ad_sum == '0);
        if (ad_sum[SW-1]) begin
            n_sig = {ad_sum[SW-1:2], ad_sum[1] | ad_sum[0]};
            n_exp = {2'b00, ad_exp} + EW'(1);
        end else begin
            n_sig = ad_sum[XW-1:0] << lz_count;
            n_exp = {2'b00, ad_exp} - EW'(lz_count);
        end
        n_underflow = !n_zero && (n_exp[EW-1] || (n_exp == '0));
    end

    // ROUND
    logic [MAN_W-1:0] r_man;
    logic             r_inc;
    logic [MAN_W+1:0] r_sig;
    logic [EW-1:0]    r_exp;
    logic [W-1:0]     r_word;
    flags_t           r_flags;

    always_comb begin
        r_man   = nm_sig[XW-2:3];
        r_inc   = (ROUND_MODE == 1) && nm_sig[2] && (nm_sig[1] || nm_sig[0] || r_man[0]);
        r_sig   = {1'b0, nm_sig[XW-1], r_man} + {{(MAN_W+1){1'b0}}, r_inc};
        r_exp   = nm_exp + EW'(r_sig[MAN_W+1]);
        r_word  = '0;
        r_flags = FLAGS_NONE;
        if (spec_q) begin
            r_word  = spec_word_q;
            r_flags = spec_flags_q;
        end else if (nm_zero) begin
            // exact cancellation is reported as negative zero
            r_word = zero_word(1'b1);
        end else if (nm_underflow) begin
            r_word            = zero_word(nm_sign);
            r_flags.underflow = 1'b1;
        end else if (r_exp >= {2'b00, EXP_ONES}) begin
            r_word           = inf_word(nm_sign);
            r_flags.overflow = 1'b1;
        end else begin
            r_word = {nm_sign, r_exp[EXP_W-1:0], r_sig[MAN_W-1:0]};
        end
    end

    // FSM
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (in_valid) state_next = ST_UNPACK;
            ST_UNPACK: state_next = ST_ALIGN;
            ST_ALIGN:  state_next = ST_ADD;
            ST_ADD:    state_next = ST_NORM;
            ST_NORM:   state_next = ST_ROUND;
            ST_ROUND:  state_next = ST_OUT;
            ST_OUT:    if (out_valid && out_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign in_ready      = (state == ST_IDLE);
    assign out_overflow  = out_flags.overflow;
    assign out_underflow = out_flags.underflow;
    assign out_invalid   = out_flags.invalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= FLAGS_NONE;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q  <= in_a;
                        b_q  <= in_b;
                        op_q <= in_op;
                    end
                end
                ST_UNPACK: begin
                    spec_q       <= u_spec;
                    spec_word_q  <= u_word;
                    spec_flags_q <= u_flags;
                    ua_sign      <= u_sign_a;
                    ua_exp       <= u_exp_a;
                    ua_man       <= u_man_a;
                    ub_sign      <= u_sign_b;
                    ub_exp       <= u_exp_b;
                    ub_man       <= u_man_b;
                end
                ST_ALIGN: begin
                    al_sign  <= big_sign;
                    al_sub   <= ua_sign ^ ub_sign;
                    al_exp   <= big_exp;
                    al_big   <= {1'b1, big_man, 3'b000};
                    al_small <= small_aligned;
                end
                ST_ADD: begin
                    ad_sum  <= sum_next;
                    ad_sign <= al_sign;
                    ad_exp  <= al_exp;
                end
                ST_NORM: begin
                    nm_sig       <= n_sig;
                    nm_exp       <= n_exp;
                    nm_sign      <= ad_sign;
                    nm_zero      <= n_zero;
                    nm_underflow <= n_underflow;
                end
                ST_ROUND: begin
                    res_word  <= r_word;
                    res_flags <= r_flags;
                end
                ST_OUT: begin
                    // first OUT cycle publishes; afterwards hold until accepted
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_result <= res_word;
                        out_flags  <= res_flags;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
